mem_access_sequencer: RTL and testbench

MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

---
 rtl/mem_access_sequencer.sv | 134 +++++++++++++
 tb/tb_mem_access_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: sequences MEM-stage load/store/LL/SC requests to the d-cache and tracks the LL reservation.
// Optional watchdog enabled by defining MEM_SEQ_TIMEOUT_EN (TIMEOUT_CYCLES sets the WAIT-state limit).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
module mem_access_sequencer #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic                   req_action,
    input  logic                   req_is_ll,
    input  logic                   req_is_sc,
    input  logic [`ADDR_WIDTH-1:0] req_addr,
    input  logic [`DATA_WIDTH-1:0] req_data,
    input  logic                   ll_clear,
    output logic                   cache_req_valid,
    output logic                   cache_mem_action,
    output logic [`ADDR_WIDTH-1:0] cache_addr,
    output logic [`DATA_WIDTH-1:0] cache_data,
    input  logic                   cache_resp_valid,
    input  logic [`DATA_WIDTH-1:0] cache_resp_data,
    output logic                   done,
    output logic [`DATA_WIDTH-1:0] rdata,
    output logic                   timeout_err
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, SC_FAIL} state_t;
    state_t                   state_q, state_d;
    logic                     act_q, act_d, ll_q, ll_d, sc_q, sc_d;
    logic                     ll_valid_q, ll_valid_d;
    logic [`ADDR_WIDTH-1:0]   addr_q, addr_d, ll_addr_q, ll_addr_d;
    logic [`DATA_WIDTH-1:0]   data_q, data_d, rdata_q, rdata_d;
    logic                     tmo;
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end
    // State, captured request, result and reservation registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            act_q      <= 1'b0;
            ll_q       <= 1'b0;
            sc_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            rdata_q    <= '0;
            ll_valid_q <= 1'b0;
            ll_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            act_q      <= act_d;
            ll_q       <= ll_d;
            sc_q       <= sc_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rdata_q    <= rdata_d;
            ll_valid_q <= ll_valid_d;
            ll_addr_q  <= ll_addr_d;
        end
    end
    // Next-state, request capture, result and reservation update; ll_clear always overrides a reservation set
    always_comb begin
        state_d    = state_q;
        act_d      = act_q;
        ll_d       = ll_q;
        sc_d       = sc_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rdata_d    = rdata_q;
        ll_addr_d  = ll_addr_q;
        ll_valid_d = ll_valid_q & ~ll_clear;
        case (state_q)
            IDLE: if (req_valid) begin
                act_d   = req_action;
                ll_d    = req_is_ll;
                sc_d    = req_is_sc;
                addr_d  = req_addr;
                data_d  = req_data;
                state_d = (req_is_sc && !(ll_valid_q && ll_addr_q == req_addr)) ? SC_FAIL : ISSUE;
                if (state_d == SC_FAIL) begin
                    rdata_d    = '0;
                    ll_valid_d = 1'b0;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: if (cache_resp_valid) begin
                state_d = DONE;
                rdata_d = (sc_q || act_q) ? `DATA_WIDTH'(1) : cache_resp_data;
                if (ll_q) begin
                    ll_valid_d = ~ll_clear;
                    ll_addr_d  = addr_q;
                end
                if (sc_q || (act_q && addr_q == ll_addr_q)) ll_valid_d = 1'b0;
            end else if (tmo) begin
                state_d    = DONE;
                rdata_d    = '0;
                ll_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
`ifdef MEM_SEQ_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_q, wd_d;
    logic          te_q, te_d;
    assign tmo  = state_q == WAIT && !cache_resp_valid && wd_q == WW'(TIMEOUT_CYCLES - 1);
    assign wd_d = (state_q == WAIT && state_d == WAIT) ? wd_q + 1'b1 : '0;
    assign te_d = te_q | tmo;
    // Watchdog counts consecutive WAIT cycles; the error flag stays set until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= '0;
            te_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            te_q <= te_d;
        end
    end
    assign timeout_err = te_q;
`else
    assign tmo         = 1'b0;
    assign timeout_err = 1'b0;
`endif
    assign cache_req_valid  = state_q == ISSUE;
    assign done             = state_q == DONE || state_q == SC_FAIL;
    assign cache_mem_action = act_q;
    assign cache_addr       = addr_q;
    assign cache_data       = data_q;
    assign rdata            = rdata_q;
endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb_mem_access_sequencer: directed transactions against a cycle-schedule and reservation model of the sequencer.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
module tb_mem_access_sequencer;
    localparam int TO = 4;
    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 1'b0, req_action = 1'b0, req_is_ll = 1'b0, req_is_sc = 1'b0, ll_clear = 1'b0;
    logic [31:0] req_addr = '0, req_data = '0, cache_resp_data = '0;
    logic cache_resp_valid = 1'b0;
    logic cache_req_valid, cache_mem_action, done, timeout_err;
    logic [31:0] cache_addr, cache_data, rdata;

    mem_access_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_action(req_action),
        .req_is_ll(req_is_ll), .req_is_sc(req_is_sc), .req_addr(req_addr), .req_data(req_data),
        .ll_clear(ll_clear), .cache_req_valid(cache_req_valid), .cache_mem_action(cache_mem_action),
        .cache_addr(cache_addr), .cache_data(cache_data), .cache_resp_valid(cache_resp_valid),
        .cache_resp_data(cache_resp_data), .done(done), .rdata(rdata), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, dn_cyc = -1, nstb = 0;
    bit chk_en = 1'b0;
    bit exp_stb [0:2047];
    bit exp_dn [0:2047];
    logic [64:0] exp_ca [0:2047];
    logic [31:0] exp_rd [0:2047];
    bit te_arm = 1'b0;
    int te_at = 0;
    bit rv = 1'b0;
    logic [31:0] ra = '0;
    int last_t = 0;

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (chk_en && cyc < 2048) begin
        chk("done", 65'(done), 65'(exp_dn[cyc]));
        chk("strobe", 65'(cache_req_valid), 65'(exp_stb[cyc]));
        if (exp_stb[cyc]) chk("cache_req", {cache_mem_action, cache_addr, cache_data}, exp_ca[cyc]);
        if (exp_dn[cyc]) chk("rdata", 65'(rdata), 65'(exp_rd[cyc]));
        chk("timeout_err", 65'(timeout_err), 65'(te_arm && cyc >= te_at));
        if (done) dn_cyc = cyc;
        if (cache_req_valid) nstb++;
    end

    // k = response delay after the strobe; k < 0 means the cache never answers
    task automatic txn(input bit act, input bit ll, input bit sc, input logic [31:0] a, input logic [31:0] d,
                       input int k, input logic [31:0] rd, input bit clr);
        int t, dc;
        bit fail;
        @(posedge clk); #1;
        t = cyc;
        last_t = t;
        dn_cyc = -1;
        req_valid = 1'b1; req_action = act; req_is_ll = ll; req_is_sc = sc; req_addr = a; req_data = d;
        fail = sc && !(rv && ra == a);
        if (fail) begin
            dc = t + 1;
            exp_rd[dc] = '0;
        end else begin
            exp_stb[t+1] = 1'b1;
            exp_ca[t+1] = {act, a, d};
            dc = (k < 0) ? t + 2 + TO : t + 2 + k;
            exp_rd[dc] = (k < 0) ? 32'd0 : (act || sc) ? 32'd1 : rd;
        end
        exp_dn[dc] = 1'b1;
        if (!fail && k >= 0) begin
            while (cyc < t + 1 + k) begin @(posedge clk); #1; end
            cache_resp_valid = 1'b1; cache_resp_data = rd; ll_clear = clr;
            @(posedge clk); #1;
            cache_resp_valid = 1'b0; ll_clear = 1'b0;
        end
        while (cyc <= dc) begin @(posedge clk); #1; end
        req_valid = 1'b0;
        if (fail || k < 0) rv = 1'b0;
        else begin
            if (ll) begin rv = 1'b1; ra = a; end
            if (sc || (act && a == ra)) rv = 1'b0;
            if (clr) rv = 1'b0;
        end
        if (!fail && k < 0) begin te_arm = 1'b1; te_at = dc; end
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1;
        ll_clear = 1'b1;
        @(posedge clk); #1;
        ll_clear = 1'b0;
        rv = 1'b0;
    endtask

    initial begin
        int s0;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_rdata", 65'(rdata), 65'd0);
        chk("rst_cache_addr", 65'(cache_addr), 65'd0);
        chk("rst_cache_data", 65'(cache_data), 65'd0);
        chk("rst_action", 65'(cache_mem_action), 65'd0);

        txn(0, 0, 0, 32'h40, 32'h0, 2, 32'hDEADBEEF, 0);
        chk("read_latency", 65'(dn_cyc - last_t), 65'd4);
        chk("read_rdata", 65'(rdata), 65'hDEADBEEF);
        txn(0, 0, 0, 32'h44, 32'h0, 1, 32'h12345678, 0);
        chk("min_latency", 65'(dn_cyc - last_t), 65'd3);
        txn(1, 0, 0, 32'h48, 32'hCAFE, 3, 32'h77777777, 0);
        chk("write_rdata", 65'(rdata), 65'd1);

        txn(0, 1, 0, 32'h80, 32'h0, 1, 32'hAAAA5555, 0);
        chk("ll_rdata", 65'(rdata), 65'hAAAA5555);
        s0 = nstb;
        txn(1, 0, 1, 32'h80, 32'h5, 2, 32'h0, 0);
        chk("sc_ok_rdata", 65'(rdata), 65'd1);
        chk("sc_ok_strobes", 65'(nstb - s0), 65'd1);
        txn(1, 0, 1, 32'h80, 32'h6, 1, 32'h0, 0);
        chk("sc_again_lat", 65'(dn_cyc - last_t), 65'd1);

        txn(0, 1, 0, 32'h80, 32'h0, 2, 32'h11110000, 0);
        txn(1, 0, 0, 32'h80, 32'h9, 1, 32'h0, 0);
        s0 = nstb;
        txn(1, 0, 1, 32'h80, 32'h5, 1, 32'h0, 0);
        chk("sc_after_sw_lat", 65'(dn_cyc - last_t), 65'd1);
        chk("sc_after_sw_rdata", 65'(rdata), 65'd0);
        chk("sc_after_sw_strobes", 65'(nstb - s0), 65'd0);

        txn(0, 1, 0, 32'h80, 32'h0, 1, 32'h2222, 0);
        txn(1, 0, 0, 32'h84, 32'h9, 2, 32'h0, 0);
        txn(1, 0, 1, 32'h80, 32'h5, 1, 32'h0, 0);
        chk("sc_other_sw_rdata", 65'(rdata), 65'd1);

        txn(0, 1, 0, 32'h80, 32'h0, 2, 32'h3333, 1);
        txn(1, 0, 1, 32'h80, 32'h5, 1, 32'h0, 0);
        chk("ll_clr_race_rdata", 65'(rdata), 65'd0);

        txn(0, 1, 0, 32'h90, 32'h0, 1, 32'h4444, 0);
        pulse_clear();
        txn(1, 0, 1, 32'h90, 32'h5, 1, 32'h0, 0);
        txn(0, 1, 0, 32'hA0, 32'h0, 1, 32'h5555, 0);
        txn(1, 0, 1, 32'hA4, 32'h5, 1, 32'h0, 0);
        txn(1, 0, 1, 32'hA0, 32'h5, 1, 32'h0, 0);
        chk("sc_fail_clears_rsv", 65'(dn_cyc - last_t), 65'd1);

`ifdef MEM_SEQ_TIMEOUT_EN
        txn(0, 1, 0, 32'h80, 32'h0, 1, 32'h6666, 0);
        txn(0, 0, 0, 32'h10, 32'h0, -1, 32'h0, 0);
        chk("timeout_lat", 65'(dn_cyc - last_t), 65'd6);
        chk("timeout_rdata", 65'(rdata), 65'd0);
        chk("timeout_flag", 65'(timeout_err), 65'd1);
        txn(1, 0, 1, 32'h80, 32'h5, 1, 32'h0, 0);
        chk("timeout_clears_rsv", 65'(dn_cyc - last_t), 65'd1);
`else
        txn(0, 0, 0, 32'h10, 32'h0, 11, 32'hBEEF0001, 0);
        chk("long_wait_lat", 65'(dn_cyc - last_t), 65'd13);
        chk("long_wait_flag", 65'(timeout_err), 65'd0);
`endif

        @(posedge clk); #1;
        last_t = cyc;
        dn_cyc = -1;
        req_valid = 1'b1; req_action = 1'b0; req_is_ll = 1'b1; req_is_sc = 1'b0; req_addr = 32'h40; req_data = 32'h0;
        exp_stb[last_t+1] = 1'b1;
        exp_ca[last_t+1] = {1'b0, 32'h40, 32'h0};
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; te_arm = 1'b0; rv = 1'b0;
        cache_resp_valid = 1'b1; cache_resp_data = 32'hFFFF0000;
        @(posedge clk); #1;
        cache_resp_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", 65'(dn_cyc), {65{1'b1}});
        chk("abort_rdata", 65'(rdata), 65'd0);
        chk("abort_cache_addr", 65'(cache_addr), 65'd0);
        chk("abort_action", 65'(cache_mem_action), 65'd0);
        chk("abort_timeout", 65'(timeout_err), 65'd0);
        txn(1, 0, 1, 32'h40, 32'h5, 1, 32'h0, 0);
        chk("abort_sc_fails", 65'(dn_cyc - last_t), 65'd1);
        txn(0, 0, 0, 32'h50, 32'h0, 2, 32'h0BADF00D, 0);
        chk("post_reset_read", 65'(rdata), 65'h0BADF00D);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
